adc_frame_responder: RTL and testbench

- Synthesizable ADC-side responder for the SF request/ready interface.
- When SF raises `req`, the block models a conversion delay, then streams one frame of 8-bit sample codes to SF. Each byte is marked by a one-cycle `rdy` strobe, and `len` is advertised for the whole frame.
- It replaces the behavioural ADC model wherever a clocked, cycle-exact sample source is needed, and sits directly opposite SF on `req`/`rdy`/`dat`/`len`.

---
 rtl/adc_frame_responder.sv | 156 +++++++++++++++
 tb/tb_adc_frame_responder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/adc_frame_responder.sv
// ADC-side responder: on a req level from SF, waits a conversion delay and then
// streams one frame of incrementing 8-bit sample codes, one rdy strobe per byte.
module adc_frame_responder #(
    parameter int unsigned FRAME_LEN   = 8,
    parameter int unsigned CONV_CYCLES = 4,
    parameter int unsigned GAP         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req,
    output logic       rdy,
    output logic [7:0] dat,
    output logic [7:0] len,
    output logic       busy
);

    localparam int unsigned DLY_MAX = (CONV_CYCLES > GAP) ? CONV_CYCLES : GAP;
    localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DLY_W-1:0] r_dly;
    logic [DLY_W-1:0] w_dly_nxt;
    logic [7:0]       r_byte_cnt;
    logic [7:0]       w_byte_cnt_nxt;
    logic [7:0]       r_code;
    logic [7:0]       w_code_nxt;
    logic             r_rdy;
    logic             w_rdy_nxt;
    logic [7:0]       r_dat;
    logic [7:0]       w_dat_nxt;
    logic [7:0]       r_len;
    logic [7:0]       w_len_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             w_emit;
    logic             w_abort;

    // State, counters and registered outputs; reset clears everything at once
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_dly      <= '0;
            r_byte_cnt <= 8'd0;
            r_code     <= 8'd0;
            r_rdy      <= 1'b0;
            r_dat      <= 8'd0;
            r_len      <= 8'd0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dly      <= w_dly_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_code     <= w_code_nxt;
            r_rdy      <= w_rdy_nxt;
            r_dat      <= w_dat_nxt;
            r_len      <= w_len_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    // Next state and next output values; a byte is emitted on the edge entering SEND
    always_comb begin
        w_state_nxt    = r_state;
        w_dly_nxt      = r_dly;
        w_byte_cnt_nxt = r_byte_cnt;
        w_code_nxt     = r_code;
        w_rdy_nxt      = 1'b0;
        w_dat_nxt      = r_dat;
        w_len_nxt      = r_len;
        w_busy_nxt     = r_busy;
        w_emit         = 1'b0;
        w_abort        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (req) begin
                    w_state_nxt    = S_CONV;
                    w_dly_nxt      = DLY_W'(CONV_CYCLES);
                    w_byte_cnt_nxt = 8'd0;
                    w_len_nxt      = 8'(FRAME_LEN);
                    w_busy_nxt     = 1'b1;
                end
            end
            S_CONV: begin
                if (!req) begin
                    w_abort = 1'b1;
                end else if (r_dly == DLY_W'(1)) begin
                    w_emit = 1'b1;
                end else begin
                    w_dly_nxt = r_dly - DLY_W'(1);
                end
            end
            S_SEND: begin
                // The last byte always completes, even if req drops on its strobe
                if (r_byte_cnt == 8'(FRAME_LEN)) begin
                    w_state_nxt = S_DONE;
                    w_len_nxt   = 8'd0;
                    w_busy_nxt  = 1'b0;
                end else if (!req) begin
                    w_abort = 1'b1;
                end else if (GAP == 0) begin
                    w_emit = 1'b1;
                end else begin
                    w_state_nxt = S_GAP;
                    w_dly_nxt   = DLY_W'(GAP);
                end
            end
            S_GAP: begin
                if (!req) begin
                    w_abort = 1'b1;
                end else if (r_dly == DLY_W'(1)) begin
                    w_emit = 1'b1;
                end else begin
                    w_dly_nxt = r_dly - DLY_W'(1);
                end
            end
            S_DONE: begin
                if (!req) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_abort) begin
            w_state_nxt = S_IDLE;
            w_len_nxt   = 8'd0;
            w_busy_nxt  = 1'b0;
        end

        if (w_emit) begin
            w_state_nxt    = S_SEND;
            w_rdy_nxt      = 1'b1;
            w_dat_nxt      = r_code;
            w_code_nxt     = r_code + 8'd1;
            w_byte_cnt_nxt = r_byte_cnt + 8'd1;
        end
    end

    assign rdy  = r_rdy;
    assign dat  = r_dat;
    assign len  = r_len;
    assign busy = r_busy;

endmodule

// File: tb/tb_adc_frame_responder.sv
// Directed bench for adc_frame_responder: default instance plus a short, gapless one.
module tb_adc_frame_responder;

    logic       clk;
    logic       rst;
    logic       req_a;
    logic       req_b;
    logic       rdy_a;
    logic       rdy_b;
    logic [7:0] dat_a;
    logic [7:0] dat_b;
    logic [7:0] len_a;
    logic [7:0] len_b;
    logic       busy_a;
    logic       busy_b;

    int checks = 0;
    int errors = 0;

    adc_frame_responder u_dut_a (
        .clk  (clk),
        .rst  (rst),
        .req  (req_a),
        .rdy  (rdy_a),
        .dat  (dat_a),
        .len  (len_a),
        .busy (busy_a)
    );

    adc_frame_responder #(
        .FRAME_LEN   (3),
        .CONV_CYCLES (1),
        .GAP         (0)
    ) u_dut_b (
        .clk  (clk),
        .rst  (rst),
        .req  (req_b),
        .rdy  (rdy_b),
        .dat  (dat_b),
        .len  (len_b),
        .busy (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise req on one instance and check every cycle from acceptance for ncyc cycles
    task automatic frame(input bit sel, input int conv, input int gap, input int flen,
                         input logic [7:0] first, input int ncyc);
        int         span;
        int         kl;
        bit         strobe;
        bit         active;
        logic [7:0] exp_dat;
        span = conv + (flen - 1) * (gap + 1) + 1;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        tick();
        for (int c = 0; c < ncyc; c++) begin
            active = (c < span);
            strobe = (c >= conv) && (((c - conv) % (gap + 1)) == 0) &&
                     (((c - conv) / (gap + 1)) < flen);
            chk(sel ? "b_rdy" : "a_rdy", 32'(sel ? rdy_b : rdy_a), 32'(strobe));
            chk(sel ? "b_busy" : "a_busy", 32'(sel ? busy_b : busy_a), 32'(active));
            chk(sel ? "b_len" : "a_len", 32'(sel ? len_b : len_a), active ? 32'(flen) : 32'd0);
            if (c >= conv) begin
                kl = (c - conv) / (gap + 1);
                if (kl > flen - 1) kl = flen - 1;
                exp_dat = first + 8'(kl);
                chk(sel ? "b_dat" : "a_dat", 32'(sel ? dat_b : dat_a), 32'(exp_dat));
            end
            tick();
        end
        if (sel) req_b = 1'b0; else req_a = 1'b0;
        tick();
    endtask

    initial begin
        rst   = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        tick();
        chk("rst_rdy", 32'(rdy_a), 32'd0);
        chk("rst_dat", 32'(dat_a), 32'd0);
        chk("rst_len", 32'(len_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        rst = 1'b1;
        tick();

        // Asynchronous reset during the gap after byte 2
        req_a = 1'b1;
        tick();
        chk("acc_busy", 32'(busy_a), 32'd1);
        chk("acc_len", 32'(len_a), 32'd8);
        chk("acc_rdy", 32'(rdy_a), 32'd0);
        repeat (8) tick();
        chk("b2_rdy", 32'(rdy_a), 32'd1);
        chk("b2_dat", 32'(dat_a), 32'h02);
        tick();
        chk("gap_rdy", 32'(rdy_a), 32'd0);
        chk("gap_dat_hold", 32'(dat_a), 32'h02);
        #2 rst = 1'b0;
        #1;
        chk("arst_rdy", 32'(rdy_a), 32'd0);
        chk("arst_dat", 32'(dat_a), 32'd0);
        chk("arst_len", 32'(len_a), 32'd0);
        chk("arst_busy", 32'(busy_a), 32'd0);
        req_a = 1'b0;
        #1 rst = 1'b1;

        // Full default frame, req held long enough to prove no retrigger
        frame(1'b0, 4, 1, 8, 8'h00, 40);
        // Req dropped for one clock, second frame continues the code sequence
        frame(1'b0, 4, 1, 8, 8'h08, 22);

        // Abort after the third strobe of a frame starting at 0x10
        req_a = 1'b1;
        tick();
        repeat (8) tick();
        chk("ab_b2_rdy", 32'(rdy_a), 32'd1);
        chk("ab_b2_dat", 32'(dat_a), 32'h12);
        req_a = 1'b0;
        tick();
        chk("ab_rdy", 32'(rdy_a), 32'd0);
        chk("ab_len", 32'(len_a), 32'd0);
        chk("ab_busy", 32'(busy_a), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ab_quiet_rdy", 32'(rdy_a), 32'd0);
            chk("ab_quiet_dat", 32'(dat_a), 32'h12);
        end
        frame(1'b0, 4, 1, 8, 8'h13, 22);

        // Short gapless instance
        frame(1'b1, 1, 0, 3, 8'h00, 8);

        // Code wrap across 32 frames into a 33rd
        tick();
        #2 rst = 1'b0;
        #2 rst = 1'b1;
        for (int f = 0; f < 33; f++) begin
            frame(1'b0, 4, 1, 8, 8'(f * 8), 20);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
